// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RISC-V funct3 encodings for memory ops (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - lsu_state_t: controller states IDLE -> REQ -> WAIT -> RESP
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Bundle of every handshake/bus signal around the LSU.
//   EXU side : in_valid/in_ready handshake, in_ren, in_wen, in_funct3, in_addr,
//              in_wdata, in_rd
//   SRAM side: mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata, mem_rdata,
//              mem_valid
//   WBU side : out_valid/out_ready handshake, out_rdata, out_rd, out_err
// Modports:
//   slave  - the LSU's own view (drives in_ready, mem_* strobes, out_*)
//   master - the surrounding environment's view (EXU, SRAM and WBU combined)
interface lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          in_valid;
    logic          in_ready;
    logic          in_ren;
    logic          in_wen;
    logic [2:0]    in_funct3;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic [4:0]    in_rd;

    logic          mem_ren;
    logic          mem_wen;
    logic [7:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_rdata;
    logic [4:0]    out_rd;
    logic          out_err;

    modport slave (
        input  in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
        output in_ready,
        output mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid,
        output out_valid, out_rdata, out_rd, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  mem_ren, mem_wen, mem_wmask, mem_addr, mem_wdata,
        output mem_rdata, mem_valid,
        input  out_valid, out_rdata, out_rd, out_err,
        output out_ready
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   Request side (fed from the incoming op):
//     req_ren, req_wen, req_funct3, req_off, req_wdata -> req_mask (byte lanes,
//     upper nibble always 0), req_data (store data shifted into its lanes),
//     req_fault (misaligned, illegal funct3, or load and store both requested)
//   Load side (fed from the captured op and the SRAM word):
//     ld_funct3, ld_off, ld_word -> ld_data (shifted down, sign/zero-extended)
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          req_ren,
    input  logic          req_wen,
    input  logic [2:0]    req_funct3,
    input  logic [1:0]    req_off,
    input  logic [DW-1:0] req_wdata,
    output logic [7:0]    req_mask,
    output logic [DW-1:0] req_data,
    output logic          req_fault,
    input  logic [2:0]    ld_funct3,
    input  logic [1:0]    ld_off,
    input  logic [DW-1:0] ld_word,
    output logic [DW-1:0] ld_data
);

    logic          illegal;
    logic          misaligned;
    logic [DW-1:0] shifted;

    // NOTE: every variable written here gets a default first, so no path
    // through the case statements can leave a latch behind.
    always_comb begin
        req_mask   = 8'h00;
        illegal    = 1'b0;
        misaligned = 1'b0;
        req_data   = req_wdata << {req_off, 3'b000};

        case (req_funct3)
            F3_B:    req_mask = {4'h0, 4'b0001 << req_off};
            F3_BU: begin
                req_mask = {4'h0, 4'b0001 << req_off};
                illegal  = req_wen;  // unsigned variants exist only for loads
            end
            F3_H: begin
                req_mask   = {4'h0, 4'b0011 << req_off};
                misaligned = req_off[0];
            end
            F3_HU: begin
                req_mask   = {4'h0, 4'b0011 << req_off};
                misaligned = req_off[0];
                illegal    = req_wen;
            end
            F3_W: begin
                req_mask   = 8'h0F;
                misaligned = (req_off != 2'b00);
            end
            default: illegal = 1'b1;
        endcase

        // An op that touches no memory can never fault.
        req_fault = (req_ren | req_wen) & (illegal | misaligned | (req_ren & req_wen));
    end

    always_comb begin
        shifted = ld_word >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{(DW-8){shifted[7]}},   shifted[7:0]};
            F3_BU:   ld_data = {{(DW-8){1'b0}},         shifted[7:0]};
            F3_H:    ld_data = {{(DW-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {{(DW-16){1'b0}},        shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one memory op in flight between EXU and SRAM.
// Ports:
//   clk - clock
//   rst - synchronous, active-low reset
//   bus - lsu_if.slave: EXU request handshake, SRAM strobes/response and
//         WBU result handshake (see lsu_if for the signal list)
// Flow: IDLE accepts an op and registers it; a legal memory op goes to REQ
// (one-cycle mem_ren/mem_wen strobe), then WAIT for mem_valid, then RESP where
// the result is held until out_ready. Faulting ops and ops with neither ren nor
// wen skip straight to RESP without touching memory. All outputs are registers.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_t    state;

    // Captured op fields needed after acceptance.
    logic          op_ren;
    logic [2:0]    op_funct3;
    logic [1:0]    op_off;
    logic [4:0]    op_rd;

    // Output registers.
    logic          in_ready_q;
    logic          mem_ren_q;
    logic          mem_wen_q;
    logic [7:0]    mem_wmask_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          out_valid_q;
    logic [DW-1:0] out_rdata_q;
    logic [4:0]    out_rd_q;
    logic          out_err_q;

    logic [7:0]    req_mask;
    logic [DW-1:0] req_data;
    logic          req_fault;
    logic [DW-1:0] ld_data;
    logic          accept;

    lsu_align #(.DW(DW)) u_align (
        .req_ren    (bus.in_ren),
        .req_wen    (bus.in_wen),
        .req_funct3 (bus.in_funct3),
        .req_off    (bus.in_addr[1:0]),
        .req_wdata  (bus.in_wdata),
        .req_mask   (req_mask),
        .req_data   (req_data),
        .req_fault  (req_fault),
        .ld_funct3  (op_funct3),
        .ld_off     (op_off),
        .ld_word    (bus.mem_rdata),
        .ld_data    (ld_data)
    );

    assign accept = bus.in_valid & in_ready_q;

    // NOTE: non-blocking assignments throughout, so every register in this
    // block updates from the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            op_ren      <= 1'b0;
            op_funct3   <= 3'b000;
            op_off      <= 2'b00;
            op_rd       <= 5'd0;
            in_ready_q  <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wmask_q <= 8'h00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_rd_q    <= 5'd0;
            out_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q  <= 1'b0;
                        op_ren      <= bus.in_ren;
                        op_funct3   <= bus.in_funct3;
                        op_off      <= bus.in_addr[1:0];
                        op_rd       <= bus.in_rd;
                        mem_addr_q  <= {bus.in_addr[AW-1:2], 2'b00};
                        mem_wdata_q <= req_data;
                        if (req_fault || !(bus.in_ren || bus.in_wen)) begin
                            state       <= RESP;
                            out_valid_q <= 1'b1;
                            out_err_q   <= req_fault;
                            out_rdata_q <= '0;
                            out_rd_q    <= bus.in_rd;
                        end else begin
                            state       <= REQ;
                            mem_ren_q   <= bus.in_ren;
                            mem_wen_q   <= bus.in_wen;
                            mem_wmask_q <= bus.in_wen ? req_mask : 8'h00;
                        end
                    end
                end

                REQ: begin
                    // Strobes last exactly this one cycle; the mask follows mem_wen.
                    mem_ren_q   <= 1'b0;
                    mem_wen_q   <= 1'b0;
                    mem_wmask_q <= 8'h00;
                    state       <= WAIT;
                end

                WAIT: begin
                    if (bus.mem_valid) begin
                        state       <= RESP;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b0;
                        out_rdata_q <= op_ren ? ld_data : '0;
                        out_rd_q    <= op_rd;
                    end
                end

                RESP: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        out_rdata_q <= '0;
                        out_rd_q    <= 5'd0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_ren   = mem_ren_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rdata = out_rdata_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl. Inputs are driven and outputs sampled on
// the falling clock edge; expected WBU results are pushed to a scoreboard when
// an op is issued and popped when out_valid is seen.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if #(.AW(32), .DW(32)) bus ();

    lsu_ctrl #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ren_cnt = 0;
    int   wen_cnt = 0;

    // Count strobes as the SRAM sees them.
    always @(posedge clk) begin
        if (bus.mem_ren === 1'b1) ren_cnt++;
        if (bus.mem_wen === 1'b1) wen_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic send(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (bus.in_ready === 1'b1);
        end
        if (ok) begin
            bus.in_valid  = 1'b1;
            bus.in_ren    = ren;
            bus.in_wen    = wen;
            bus.in_funct3 = f3;
            bus.in_addr   = addr;
            bus.in_wdata  = wdata;
            bus.in_rd     = rd;
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.in_ren    = 1'b0;
            bus.in_wen    = 1'b0;
        end
    endtask

    task automatic mem_reply(input logic [31:0] word);
        bus.mem_rdata = word;
        bus.mem_valid = 1'b1;
        @(negedge clk);
        bus.mem_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = (bus.out_valid === 1'b1);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (bus.out_valid === 1'b1);
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.mem_ren, bus.mem_wen, bus.mem_wmask, bus.mem_addr,
             bus.mem_wdata, bus.out_valid, bus.out_rdata, bus.out_rd, bus.out_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got in_ready=%b ren=%b wen=%b mask=%h addr=%h wdata=%h ov=%b rdata=%h rd=%0d err=%b, expected all 0",
                     bus.in_ready, bus.mem_ren, bus.mem_wen, bus.mem_wmask, bus.mem_addr,
                     bus.mem_wdata, bus.out_valid, bus.out_rdata, bus.out_rd, bus.out_err);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_store_word();
        bit   ok;
        int   w0;
        exp_t e;
        w0 = wen_cnt;
        send(1'b0, 1'b1, F3_W, 32'h8000_0004, 32'hDEAD_BEEF, 5'd5, ok);
        sb.push_back('{rdata: 32'h0, rd: 5'd5, err: 1'b0});
        checks++;
        if (!ok) begin errors++; $display("FAIL sw_accept: in_ready never seen, expected accept"); end
        checks++;
        if ({bus.mem_wen, bus.mem_ren, bus.mem_wmask} !== {1'b1, 1'b0, 8'h0F}) begin
            errors++;
            $display("FAIL sw_strobe: got wen=%b ren=%b mask=%h, expected 1 0 0f", bus.mem_wen, bus.mem_ren, bus.mem_wmask);
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {32'h8000_0004, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sw_addr_data: got addr=%h wdata=%h, expected 80000004 deadbeef", bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);  // WAIT
        checks++;
        if ({bus.mem_wen, bus.mem_wmask, bus.out_valid, bus.mem_addr, bus.mem_wdata}
            !== {1'b0, 8'h00, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sw_wait: got wen=%b mask=%h ov=%b addr=%h wdata=%h, expected 0 00 0 80000004 deadbeef",
                     bus.mem_wen, bus.mem_wmask, bus.out_valid, bus.mem_addr, bus.mem_wdata);
        end
        mem_reply(32'hFFFF_FFFF);
        wait_out(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++; $display("FAIL sw_result: out_valid=%b sb_size=%0d, expected valid result", bus.out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if ({bus.out_rdata, bus.out_rd, bus.out_err} !== {e.rdata, e.rd, e.err}) begin
                errors++;
                $display("FAIL sw_result: got rdata=%h rd=%0d err=%b, expected %h %0d %b",
                         bus.out_rdata, bus.out_rd, bus.out_err, e.rdata, e.rd, e.err);
            end
        end
        checks++;
        if (wen_cnt - w0 !== 1) begin
            errors++; $display("FAIL sw_wen_count: got %0d, expected 1", wen_cnt - w0);
        end
        release_out();
    endtask

    task automatic test_stores();
        typedef struct packed {
            logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
            logic [7:0] mask; logic [31:0] mdata; logic [31:0] maddr;
        } st_vec_t;
        st_vec_t tbl [3] = '{
            '{F3_B, 32'h8000_0003, 32'h0000_00A5, 8'h08, 32'hA500_0000, 32'h8000_0000},
            '{F3_H, 32'h8000_0002, 32'h0000_1234, 8'h0C, 32'h1234_0000, 32'h8000_0000},
            '{F3_B, 32'h8000_0011, 32'h0000_005A, 8'h02, 32'h0000_5A00, 32'h8000_0010}
        };
        bit   ok;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b1, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 5'(i + 10), ok);
            sb.push_back('{rdata: 32'h0, rd: 5'(i + 10), err: 1'b0});
            checks++;
            if (!ok || {bus.mem_wen, bus.mem_wmask, bus.mem_wdata, bus.mem_addr}
                       !== {1'b1, tbl[i].mask, tbl[i].mdata, tbl[i].maddr}) begin
                errors++;
                $display("FAIL store_req[%0d]: got wen=%b mask=%h wdata=%h addr=%h, expected 1 %h %h %h",
                         i, bus.mem_wen, bus.mem_wmask, bus.mem_wdata, bus.mem_addr,
                         tbl[i].mask, tbl[i].mdata, tbl[i].maddr);
            end
            @(negedge clk);
            mem_reply(32'hFFFF_FFFF);
            wait_out(ok);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++; $display("FAIL store_result[%0d]: out_valid=%b, expected 1", i, bus.out_valid);
            end else begin
                e = sb.pop_front();
                if ({bus.out_rdata, bus.out_rd, bus.out_err} !== {e.rdata, e.rd, e.err}) begin
                    errors++;
                    $display("FAIL store_result[%0d]: got rdata=%h rd=%0d err=%b, expected %h %0d %b",
                             i, bus.out_rdata, bus.out_rd, bus.out_err, e.rdata, e.rd, e.err);
                end
            end
            release_out();
        end
    endtask

    task automatic test_loads();
        typedef struct packed {
            logic [2:0] f3; logic [31:0] addr; logic [31:0] word; logic [31:0] res;
        } ld_vec_t;
        ld_vec_t tbl [6] = '{
            '{F3_B,  32'h8000_0002, 32'h12F0_5678, 32'hFFFF_FFF0},
            '{F3_BU, 32'h8000_0002, 32'h12F0_5678, 32'h0000_00F0},
            '{F3_HU, 32'h8000_0002, 32'h12F0_5678, 32'h0000_12F0},
            '{F3_H,  32'h8000_0000, 32'h12F0_8765, 32'hFFFF_8765},
            '{F3_W,  32'h8000_0000, 32'h12F0_8765, 32'h12F0_8765},
            '{F3_B,  32'h8000_0001, 32'h0000_80FF, 32'hFFFF_FF80}
        };
        bit   ok;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 1'b0, tbl[i].f3, tbl[i].addr, 32'h0, 5'(i + 1), ok);
            sb.push_back('{rdata: tbl[i].res, rd: 5'(i + 1), err: 1'b0});
            checks++;
            if (!ok || {bus.mem_ren, bus.mem_wen, bus.mem_wmask, bus.mem_addr}
                       !== {1'b1, 1'b0, 8'h00, tbl[i].addr[31:2], 2'b00}) begin
                errors++;
                $display("FAIL load_req[%0d]: got ren=%b wen=%b mask=%h addr=%h, expected 1 0 00 %h",
                         i, bus.mem_ren, bus.mem_wen, bus.mem_wmask, bus.mem_addr,
                         {tbl[i].addr[31:2], 2'b00});
            end
            @(negedge clk);
            mem_reply(tbl[i].word);
            wait_out(ok);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++; $display("FAIL load_result[%0d]: out_valid=%b, expected 1", i, bus.out_valid);
            end else begin
                e = sb.pop_front();
                if ({bus.out_rdata, bus.out_rd, bus.out_err} !== {e.rdata, e.rd, e.err}) begin
                    errors++;
                    $display("FAIL load_result[%0d]: got rdata=%h rd=%0d err=%b, expected %h %0d %b",
                             i, bus.out_rdata, bus.out_rd, bus.out_err, e.rdata, e.rd, e.err);
                end
            end
            release_out();
        end
    endtask

    task automatic test_faults();
        typedef struct packed {
            logic ren; logic wen; logic [2:0] f3; logic [31:0] addr; logic err;
        } f_vec_t;
        f_vec_t tbl [5] = '{
            '{1'b1, 1'b0, F3_W,   32'h8000_0006, 1'b1},  // misaligned word load
            '{1'b0, 1'b1, F3_H,   32'h8000_0001, 1'b1},  // misaligned half store
            '{1'b1, 1'b0, 3'b011, 32'h8000_0000, 1'b1},  // unlisted funct3
            '{1'b1, 1'b1, F3_W,   32'h8000_0000, 1'b1},  // load and store together
            '{1'b0, 1'b0, F3_W,   32'h8000_0000, 1'b0}   // no memory op
        };
        bit   ok;
        int   r0, w0;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            r0 = ren_cnt;
            w0 = wen_cnt;
            send(tbl[i].ren, tbl[i].wen, tbl[i].f3, tbl[i].addr, 32'h1234_5678, 5'(i + 20), ok);
            sb.push_back('{rdata: 32'h0, rd: 5'(i + 20), err: tbl[i].err});
            // Result must be present on the very next cycle after acceptance.
            checks++;
            if (!ok || bus.out_valid !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL fault_latency[%0d]: got out_valid=%b, expected 1", i, bus.out_valid);
            end else begin
                e = sb.pop_front();
                if ({bus.out_rdata, bus.out_rd, bus.out_err} !== {e.rdata, e.rd, e.err}) begin
                    errors++;
                    $display("FAIL fault_result[%0d]: got rdata=%h rd=%0d err=%b, expected %h %0d %b",
                             i, bus.out_rdata, bus.out_rd, bus.out_err, e.rdata, e.rd, e.err);
                end
            end
            release_out();
            @(negedge clk);
            checks++;
            if (ren_cnt != r0 || wen_cnt != w0) begin
                errors++;
                $display("FAIL fault_no_strobe[%0d]: got ren=%0d wen=%0d strobes, expected 0 0",
                         i, ren_cnt - r0, wen_cnt - w0);
            end
        end
    endtask

    task automatic test_stall();
        bit   ok;
        exp_t e;
        send(1'b1, 1'b0, F3_W, 32'h8000_0008, 32'h0, 5'd9, ok);
        sb.push_back('{rdata: 32'hCAFE_F00D, rd: 5'd9, err: 1'b0});
        @(negedge clk);
        mem_reply(32'hCAFE_F00D);
        wait_out(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++; $display("FAIL stall_result: out_valid=%b, expected 1", bus.out_valid);
            e = '0;
        end else begin
            e = sb.pop_front();
            if ({bus.out_rdata, bus.out_rd, bus.out_err} !== {e.rdata, e.rd, e.err}) begin
                errors++;
                $display("FAIL stall_result: got rdata=%h rd=%0d err=%b, expected %h %0d %b",
                         bus.out_rdata, bus.out_rd, bus.out_err, e.rdata, e.rd, e.err);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_rdata, bus.out_rd, bus.in_ready} !== {1'b1, e.rdata, e.rd, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got ov=%b rdata=%h rd=%0d in_ready=%b, expected 1 %h %0d 0",
                         i, bus.out_valid, bus.out_rdata, bus.out_rd, bus.in_ready, e.rdata, e.rd);
            end
        end
        release_out();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        bit   ok;
        bit   seen_valid;
        exp_t e;
        send(1'b1, 1'b0, F3_W, 32'h8000_0000, 32'h0, 5'd3, ok);
        @(negedge clk);  // WAIT
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.mem_ren !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got ov=%b in_ready=%b ren=%b, expected 0 0 0",
                     bus.out_valid, bus.in_ready, bus.mem_ren);
        end
        rst = 1'b1;
        mem_reply(32'h5555_AAAA);  // late completion of the dropped op
        seen_valid = (bus.out_valid === 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_ready: got in_ready=%b, expected 1", bus.in_ready);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            errors++; $display("FAIL midreset_ignored: got out_valid=1 after reset, expected 0");
        end
        sb.delete();  // the in-flight op was dropped

        send(1'b1, 1'b0, F3_W, 32'h8000_0000, 32'h0, 5'd4, ok);
        sb.push_back('{rdata: 32'h0BAD_CAFE, rd: 5'd4, err: 1'b0});
        @(negedge clk);
        mem_reply(32'h0BAD_CAFE);
        wait_out(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++; $display("FAIL postreset_result: out_valid=%b, expected 1", bus.out_valid);
        end else begin
            e = sb.pop_front();
            if ({bus.out_rdata, bus.out_rd, bus.out_err} !== {e.rdata, e.rd, e.err}) begin
                errors++;
                $display("FAIL postreset_result: got rdata=%h rd=%0d err=%b, expected %h %0d %b",
                         bus.out_rdata, bus.out_rd, bus.out_err, e.rdata, e.rd, e.err);
            end
        end
        release_out();
    endtask

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ren    = 1'b0;
        bus.in_wen    = 1'b0;
        bus.in_funct3 = 3'b000;
        bus.in_addr   = 32'h0;
        bus.in_wdata  = 32'h0;
        bus.in_rd     = 5'd0;
        bus.mem_rdata = 32'h0;
        bus.mem_valid = 1'b0;
        bus.out_ready = 1'b0;

        test_reset();
        test_store_word();
        test_stores();
        test_loads();
        test_faults();
        test_stall();
        test_reset_inflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
